// File: rtl/apb_gpi_irq_pkg.sv
// Shared register offsets, address decode enum and ISR update helper for apb_gpi_irq.
package gpi_pkg;

  localparam logic [4:0] GPI_CR_OFS   = 5'h00;
  localparam logic [4:0] GPI_IDR_OFS  = 5'h04;
  localparam logic [4:0] GPI_RISE_OFS = 5'h08;
  localparam logic [4:0] GPI_FALL_OFS = 5'h0C;
  localparam logic [4:0] GPI_IER_OFS  = 5'h10;
  localparam logic [4:0] GPI_ISR_OFS  = 5'h14;

  typedef enum logic [2:0] {
    GPI_REG_CR   = 3'd0,
    GPI_REG_IDR  = 3'd1,
    GPI_REG_RISE = 3'd2,
    GPI_REG_FALL = 3'd3,
    GPI_REG_IER  = 3'd4,
    GPI_REG_ISR  = 3'd5,
    GPI_REG_RSV6 = 3'd6,
    GPI_REG_RSV7 = 3'd7
  } gpi_reg_e;

  typedef enum logic {
    APB_IDLE = 1'b0,
    APB_ACK  = 1'b1
  } apb_state_e;

  // Clear is applied first so a coincident set always survives.
  function automatic logic [31:0] gpi_isr_next(input logic [31:0] isr,
                                               input logic [31:0] set,
                                               input logic [31:0] w1c);
    return (isr & ~w1c) | set;
  endfunction

endpackage

// File: rtl/apb_gpi_irq_if.sv
// APB slave bus bundle for apb_gpi_irq; the master drives, the peripheral responds.
interface apb_gpi_irq_if;
  logic [4:0]  PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (output PADDR, PWRITE, PENABLE, PSEL, PWDATA,
                  input  PRDATA, PREADY);
  modport slave  (input  PADDR, PWRITE, PENABLE, PSEL, PWDATA,
                  output PRDATA, PREADY);
endinterface

// File: rtl/apb_gpi_irq_in_ch.sv
// One input pin: synchroniser, optional debouncer (GPI_DEBOUNCE_EN), prev flop, edge strobes.
module gpi_in_ch #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPI_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Counter tracks consecutive disagreeing cycles; the last one flips filt.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync != filt_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) filt_d = sync;
      else                              cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
`else
  assign filt_o = sync;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b0;
    else         prev_q <= filt_o;
  end

  assign rise_o = filt_o & ~prev_q;
  assign fall_o = ~filt_o & prev_q;

endmodule

// File: rtl/apb_gpi_irq.sv
// APB general-purpose input block with edge-latched W1C interrupt status and level irq.
// Optional per-pin debounce is enabled by defining GPI_DEBOUNCE_EN.
module apb_gpi_irq
  import gpi_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_gpi_irq_if.slave     apb,
  input  logic [WIDTH-1:0] gpi,
  output logic             irq
);

  logic [WIDTH-1:0] filt, rise, fall;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    gpi_in_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_ch (
      .clk_i  (PCLK),
      .rst_ni (PRESETn),
      .pin_i  (gpi[i]),
      .filt_o (filt[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

  apb_state_e       state_q;
  logic             pready_q;
  logic [31:0]      prdata_q;

  logic [WIDTH-1:0] cr_q, cr_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] ier_q, ier_d;
  logic [WIDTH-1:0] isr_q, isr_d;

  logic             access, wr;
  gpi_reg_e         sel;
  logic [WIDTH-1:0] wdata, w1c, isr_set;
  logic [31:0]      isr_full, rdata;
  logic             unused_bits;

  assign access = apb.PSEL & apb.PENABLE & ~pready_q;
  assign wr     = access & apb.PWRITE;
  assign sel    = gpi_reg_e'(apb.PADDR[4:2]);
  assign wdata  = apb.PWDATA[WIDTH-1:0];
  assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

  always_comb begin
    cr_d      = cr_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    ier_d     = ier_q;
    w1c       = '0;
    if (wr) begin
      case (sel)
        GPI_REG_CR:   cr_d      = wdata;
        GPI_REG_RISE: rise_en_d = wdata;
        GPI_REG_FALL: fall_en_d = wdata;
        GPI_REG_IER:  ier_d     = wdata;
        GPI_REG_ISR:  w1c       = wdata;
        default: ;
      endcase
    end
    isr_set  = cr_q & ((rise & rise_en_q) | (fall & fall_en_q));
    isr_full = gpi_isr_next(32'(isr_q), 32'(isr_set), 32'(w1c));
    isr_d    = isr_full[WIDTH-1:0];
  end

  always_comb begin
    rdata = '0;
    case (sel)
      GPI_REG_CR:   rdata[WIDTH-1:0] = cr_q;
      GPI_REG_IDR:  rdata[WIDTH-1:0] = filt & cr_q;
      GPI_REG_RISE: rdata[WIDTH-1:0] = rise_en_q;
      GPI_REG_FALL: rdata[WIDTH-1:0] = fall_en_q;
      GPI_REG_IER:  rdata[WIDTH-1:0] = ier_q;
      GPI_REG_ISR:  rdata[WIDTH-1:0] = isr_q;
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cr_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      ier_q     <= '0;
      isr_q     <= '0;
    end else begin
      cr_q      <= cr_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      ier_q     <= ier_d;
      isr_q     <= isr_d;
    end
  end

  // ACK always returns to IDLE, so an access still held during ACK is not repeated.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= APB_IDLE;
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      case (state_q)
        APB_IDLE: begin
          if (access) begin
            state_q  <= APB_ACK;
            pready_q <= 1'b1;
            if (!apb.PWRITE) prdata_q <= rdata;
          end
        end
        APB_ACK: begin
          state_q  <= APB_IDLE;
          pready_q <= 1'b0;
        end
        default: begin
          state_q  <= APB_IDLE;
          pready_q <= 1'b0;
        end
      endcase
    end
  end

  assign apb.PRDATA = prdata_q;
  assign apb.PREADY = pready_q;
  assign irq        = |(isr_q & ier_q);

endmodule

// File: tb/tb_apb_gpi_irq.sv
// Directed self-checking bench for apb_gpi_irq (WIDTH=8, SYNC_STAGES=2, DEB_CYCLES=4).
module tb_apb_gpi_irq;
  import gpi_pkg::*;

  localparam int unsigned WIDTH = 8;
`ifdef GPI_DEBOUNCE_EN
  localparam int LAT = 2 + 4;
`else
  localparam int LAT = 2;
`endif

  logic             PCLK = 1'b0;
  logic             PRESETn;
  logic [WIDTH-1:0] gpi;
  logic             irq;
  int               ncmp = 0;
  int               nfail = 0;

  apb_gpi_irq_if bus ();

  apb_gpi_irq #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2),
    .DEB_CYCLES  (4)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .apb     (bus),
    .gpi     (gpi),
    .irq     (irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output int lat);
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    lat = 0;
    do begin @(negedge PCLK); lat++; end while (bus.PREADY !== 1'b1 && lat < 16);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output int lat);
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    lat = 0;
    do begin @(negedge PCLK); lat++; end while (bus.PREADY !== 1'b1 && lat < 16);
    d = bus.PRDATA;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int lat;
    PRESETn = 1'b0; gpi = '0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    repeat (3) @(negedge PCLK);
    ncmp++; if (bus.PRDATA !== 32'h0) begin nfail++; $display("FAIL rst_prdata: got %h expected %h", bus.PRDATA, 32'h0); end
    ncmp++; if (bus.PREADY !== 1'b0) begin nfail++; $display("FAIL rst_pready: got %b expected 0", bus.PREADY); end
    ncmp++; if (irq !== 1'b0) begin nfail++; $display("FAIL rst_irq: got %b expected 0", irq); end
    PRESETn = 1'b1;
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = GPI_CR_OFS; bus.PWDATA = 32'hFF;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    @(posedge PCLK); #1;
    ncmp++; if (bus.PREADY !== 1'b0) begin nfail++; $display("FAIL abort_pready: got %b expected 0", bus.PREADY); end
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apb_read(5'(i * 4), d, lat);
      ncmp++; if (d !== 32'h0) begin nfail++; $display("FAIL rst_read[%0d]: got %h expected %h", i, d, 32'h0); end
    end
    ncmp++; if (irq !== 1'b0) begin nfail++; $display("FAIL rst_irq_after: got %b expected 0", irq); end
  endtask

  task automatic test_handshake();
    logic [31:0] d;
    int lat;
    apb_write(GPI_CR_OFS, 32'hFF, lat);
    ncmp++; if (lat !== 1) begin nfail++; $display("FAIL wr_ready_lat: got %0d expected 1", lat); end
    ncmp++; if (bus.PREADY !== 1'b0) begin nfail++; $display("FAIL pready_drop: got %b expected 0", bus.PREADY); end
    apb_read(GPI_CR_OFS, d, lat);
    ncmp++; if (lat !== 1) begin nfail++; $display("FAIL rd_ready_lat: got %0d expected 1", lat); end
    ncmp++; if (d !== 32'hFF) begin nfail++; $display("FAIL cr_readback: got %h expected %h", d, 32'hFF); end
    apb_read(5'h1C, d, lat);
    ncmp++; if (d !== 32'h0) begin nfail++; $display("FAIL unmapped_1c: got %h expected %h", d, 32'h0); end
    apb_write(GPI_CR_OFS, 32'hFFFF_FF33, lat);
    apb_write(5'h18, 32'hFFFF_FFFF, lat);
    apb_read(5'h18, d, lat);
    ncmp++; if (d !== 32'h0) begin nfail++; $display("FAIL unmapped_18: got %h expected %h", d, 32'h0); end
    apb_read(GPI_CR_OFS, d, lat);
    ncmp++; if (d !== 32'h33) begin nfail++; $display("FAIL cr_upper_ignored: got %h expected %h", d, 32'h33); end
    apb_write(GPI_IER_OFS, 32'h0, lat);
    ncmp++; if (bus.PRDATA !== 32'h33) begin nfail++; $display("FAIL prdata_hold: got %h expected %h", bus.PRDATA, 32'h33); end
  endtask

  task automatic test_input_read();
    logic [31:0] d;
    int lat;
    apb_write(GPI_CR_OFS, 32'h0F, lat);
    @(negedge PCLK);
    gpi = 8'hA5;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = GPI_IDR_OFS;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    // commit edge is the 2nd edge after gpi changed: IDR must still show the old value
    ncmp++; if (bus.PRDATA !== 32'h0) begin nfail++; $display("FAIL idr_early: got %h expected %h", bus.PRDATA, 32'h0); end
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    repeat (LAT - 2) @(negedge PCLK);
    apb_read(GPI_IDR_OFS, d, lat);
    ncmp++; if (d !== 32'h05) begin nfail++; $display("FAIL idr_a5: got %h expected %h", d, 32'h05); end
    gpi = 8'h5A;
    repeat (LAT + 1) @(negedge PCLK);
    apb_read(GPI_IDR_OFS, d, lat);
    ncmp++; if (d !== 32'h0A) begin nfail++; $display("FAIL idr_5a: got %h expected %h", d, 32'h0A); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    int lat;
    apb_write(GPI_CR_OFS,   32'h01, lat);
    apb_write(GPI_RISE_OFS, 32'h01, lat);
    apb_write(GPI_FALL_OFS, 32'h00, lat);
    apb_write(GPI_IER_OFS,  32'h01, lat);
    gpi = 8'h00;
    repeat (LAT + 3) @(negedge PCLK);
    apb_write(GPI_ISR_OFS, 32'hFF, lat);
    apb_read(GPI_ISR_OFS, d, lat);
    ncmp++; if (d !== 32'h0) begin nfail++; $display("FAIL isr_clean: got %h expected %h", d, 32'h0); end
    @(negedge PCLK);
    gpi[0] = 1'b1;
    for (int e = 1; e <= LAT + 1; e++) begin
      @(negedge PCLK);
      ncmp++;
      if (irq !== (e == LAT + 1)) begin
        nfail++; $display("FAIL rise_irq_edge%0d: got %b expected %b", e, irq, (e == LAT + 1));
      end
    end
    apb_read(GPI_ISR_OFS, d, lat);
    ncmp++; if (d !== 32'h01) begin nfail++; $display("FAIL isr_rise: got %h expected %h", d, 32'h01); end
    apb_write(GPI_ISR_OFS, 32'h01, lat);
    apb_read(GPI_ISR_OFS, d, lat);
    ncmp++; if (d !== 32'h0) begin nfail++; $display("FAIL isr_w1c: got %h expected %h", d, 32'h0); end
    ncmp++; if (irq !== 1'b0) begin nfail++; $display("FAIL irq_w1c: got %b expected 0", irq); end
    gpi[0] = 1'b0;
    repeat (LAT + 3) @(negedge PCLK);
    apb_read(GPI_ISR_OFS, d, lat);
    ncmp++; if (d !== 32'h0) begin nfail++; $display("FAIL fall_no_set: got %h expected %h", d, 32'h0); end
    apb_write(GPI_RISE_OFS, 32'h00, lat);
    apb_write(GPI_FALL_OFS, 32'h01, lat);
    gpi[0] = 1'b1;
    repeat (LAT + 3) @(negedge PCLK);
    apb_read(GPI_ISR_OFS, d, lat);
    ncmp++; if (d !== 32'h0) begin nfail++; $display("FAIL rise_disabled: got %h expected %h", d, 32'h0); end
    gpi[0] = 1'b0;
    repeat (LAT + 3) @(negedge PCLK);
    apb_read(GPI_ISR_OFS, d, lat);
    ncmp++; if (d !== 32'h01) begin nfail++; $display("FAIL isr_fall: got %h expected %h", d, 32'h01); end
    apb_write(GPI_IER_OFS, 32'h00, lat);
    ncmp++; if (irq !== 1'b0) begin nfail++; $display("FAIL irq_masked: got %b expected 0", irq); end
    apb_write(GPI_CR_OFS, 32'h00, lat);
    apb_read(GPI_ISR_OFS, d, lat);
    ncmp++; if (d !== 32'h01) begin nfail++; $display("FAIL isr_retained: got %h expected %h", d, 32'h01); end
    gpi[0] = 1'b1;
    repeat (LAT + 3) @(negedge PCLK);
    gpi[0] = 1'b0;
    apb_write(GPI_ISR_OFS, 32'hFF, lat);
    repeat (LAT + 3) @(negedge PCLK);
    apb_read(GPI_ISR_OFS, d, lat);
    ncmp++; if (d !== 32'h0) begin nfail++; $display("FAIL cr0_no_set: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_set_vs_clear();
    logic [31:0] d;
    int lat;
    apb_write(GPI_CR_OFS,   32'h01, lat);
    apb_write(GPI_RISE_OFS, 32'h01, lat);
    apb_write(GPI_FALL_OFS, 32'h00, lat);
    apb_write(GPI_IER_OFS,  32'h01, lat);
    apb_write(GPI_ISR_OFS,  32'hFF, lat);
    @(negedge PCLK);
    gpi[0] = 1'b1;
    repeat (LAT - 2) @(negedge PCLK);
    // W1C commits on the same edge that the rise sets ISR[0]
    apb_write(GPI_ISR_OFS, 32'h01, lat);
    ncmp++; if (irq !== 1'b1) begin nfail++; $display("FAIL svc_irq: got %b expected 1", irq); end
    apb_read(GPI_ISR_OFS, d, lat);
    ncmp++; if (d !== 32'h01) begin nfail++; $display("FAIL svc_isr: got %h expected %h", d, 32'h01); end
    apb_write(GPI_ISR_OFS, 32'h01, lat);
    ncmp++; if (irq !== 1'b0) begin nfail++; $display("FAIL svc_clear_irq: got %b expected 0", irq); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int lat;
    apb_write(GPI_RISE_OFS, 32'hA5, lat);
    apb_write(GPI_FALL_OFS, 32'h3C, lat);
    apb_read(GPI_RISE_OFS, d, lat);
    ncmp++; if (d !== 32'hA5) begin nfail++; $display("FAIL b2b_rise: got %h expected %h", d, 32'hA5); end
    apb_read(GPI_FALL_OFS, d, lat);
    ncmp++; if (d !== 32'h3C) begin nfail++; $display("FAIL b2b_fall: got %h expected %h", d, 32'h3C); end
  endtask

`ifdef GPI_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] d;
    int lat;
    apb_write(GPI_CR_OFS,   32'h02, lat);
    apb_write(GPI_RISE_OFS, 32'h02, lat);
    apb_write(GPI_FALL_OFS, 32'h00, lat);
    apb_write(GPI_IER_OFS,  32'h00, lat);
    gpi = 8'h00;
    repeat (LAT + 4) @(negedge PCLK);
    apb_write(GPI_ISR_OFS, 32'hFF, lat);
    @(negedge PCLK);
    gpi[1] = 1'b1;
    repeat (3) @(negedge PCLK);
    gpi[1] = 1'b0;
    apb_read(GPI_IDR_OFS, d, lat);
    ncmp++; if (d !== 32'h0) begin nfail++; $display("FAIL deb_short_idr: got %h expected %h", d, 32'h0); end
    repeat (10) @(negedge PCLK);
    apb_read(GPI_ISR_OFS, d, lat);
    ncmp++; if (d !== 32'h0) begin nfail++; $display("FAIL deb_short_isr: got %h expected %h", d, 32'h0); end
    @(negedge PCLK);
    gpi[1] = 1'b1;
    repeat (6) @(negedge PCLK);
    gpi[1] = 1'b0;
    apb_read(GPI_IDR_OFS, d, lat);
    ncmp++; if (d !== 32'h02) begin nfail++; $display("FAIL deb_long_idr: got %h expected %h", d, 32'h02); end
    repeat (10) @(negedge PCLK);
    apb_read(GPI_ISR_OFS, d, lat);
    ncmp++; if (d !== 32'h02) begin nfail++; $display("FAIL deb_long_isr: got %h expected %h", d, 32'h02); end
    apb_read(GPI_IDR_OFS, d, lat);
    ncmp++; if (d !== 32'h0) begin nfail++; $display("FAIL deb_long_idr_end: got %h expected %h", d, 32'h0); end
  endtask
`endif

  initial begin
    test_reset();
    test_handshake();
    test_input_read();
    test_edge_irq();
    test_set_vs_clear();
    test_back_to_back();
`ifdef GPI_DEBOUNCE_EN
    test_debounce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
